// File: rtl/io_input_bank_if.sv
// CPU-side bus of the I/O input-port bank: byte address, write strobe and data,
// plus the combinational read data and the level interrupt.
interface io_input_bank_if;
    logic [31:0] addr;
    logic        io_wr;
    logic [31:0] io_wdata;
    logic [31:0] io_read_data;
    logic        io_irq;

    modport master (output addr, io_wr, io_wdata, input io_read_data, io_irq);
    modport slave  (input addr, io_wr, io_wdata, output io_read_data, io_irq);
endinterface

// File: rtl/io_input_bank.sv
// Memory-mapped bank of NPORTS synchronised, optionally debounced input ports
// with sticky W1C change flags and a maskable level interrupt.
module io_input_bank #(
    parameter int NPORTS      = 3,
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 0
) (
    input  logic                    io_clk,
    input  logic                    reset,
    input  logic [NPORTS*WIDTH-1:0] in_port,
    io_input_bank_if.slave          bus
);
    localparam logic [5:0] IDX_STATUS = 6'h10;
    localparam logic [5:0] IDX_IRQ_EN = 6'h11;
    localparam int         CNT_W      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [NPORTS*WIDTH-1:0] w_in_flat;
    logic [NPORTS-1:0]       w_set;
    logic [NPORTS-1:0]       w_clr;
    logic [NPORTS-1:0]       r_chg;
    logic [NPORTS-1:0]       r_irq_en;
    logic [5:0]              w_idx;
    logic                    w_wr_status;
    logic                    w_wr_irq_en;
    logic [31:0]             w_rdata;

    assign w_idx       = bus.addr[7:2];
    assign w_wr_status = bus.io_wr && (w_idx == IDX_STATUS);
    assign w_wr_irq_en = bus.io_wr && (w_idx == IDX_IRQ_EN);

    genvar g;
    for (g = 0; g < NPORTS; g++) begin : g_port
        logic [WIDTH-1:0] r_sync [SYNC_STAGES];
        logic [WIDTH-1:0] r_in_reg;
        logic [WIDTH-1:0] w_sync_out;
        logic [WIDTH-1:0] w_in_next;

        always_ff @(posedge io_clk or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            end else begin
                r_sync[0] <= in_port[g*WIDTH +: WIDTH];
                for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            end
        end

        assign w_sync_out = r_sync[SYNC_STAGES-1];

        if (DEBOUNCE == 0) begin : g_nodb
            assign w_in_next = w_sync_out;
        end else begin : g_db
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
            logic [WIDTH-1:0] r_cand;
            logic [CNT_W-1:0] r_cnt;
            logic             w_commit;

            // Commit only after the candidate has matched for DEBOUNCE cycles.
            assign w_commit  = (w_sync_out == r_cand) && (r_cand != r_in_reg) &&
                               (r_cnt == CNT_LAST);
            assign w_in_next = w_commit ? r_cand : r_in_reg;

            always_ff @(posedge io_clk or posedge reset) begin
                if (reset) begin
                    r_cand <= '0;
                    r_cnt  <= '0;
                end else if (w_sync_out != r_cand) begin
                    r_cand <= w_sync_out;
                    r_cnt  <= '0;
                end else if (r_cand != r_in_reg) begin
                    r_cnt  <= w_commit ? '0 : r_cnt + CNT_W'(1);
                end else begin
                    r_cnt  <= '0;
                end
            end
        end

        always_ff @(posedge io_clk or posedge reset) begin
            if (reset) r_in_reg <= '0;
            else       r_in_reg <= w_in_next;
        end

        assign w_in_flat[g*WIDTH +: WIDTH] = r_in_reg;
        assign w_set[g] = (w_in_next != r_in_reg);
        assign w_clr[g] = w_wr_status && bus.io_wdata[g];
    end

    // A new change on the same edge as a W1C clear keeps the flag set.
    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            r_chg    <= '0;
            r_irq_en <= '0;
        end else begin
            r_chg <= w_set | (r_chg & ~w_clr);
            if (w_wr_irq_en) r_irq_en <= bus.io_wdata[NPORTS-1:0];
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_idx == IDX_STATUS) begin
            w_rdata[NPORTS-1:0] = r_chg;
        end else if (w_idx == IDX_IRQ_EN) begin
            w_rdata[NPORTS-1:0] = r_irq_en;
        end else begin
            for (int i = 0; i < NPORTS; i++) begin
                if (w_idx == 6'(i)) w_rdata[WIDTH-1:0] = w_in_flat[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus.io_read_data = w_rdata;
    assign bus.io_irq       = |(r_chg & r_irq_en);
endmodule

// File: tb/tb_io_input_bank.sv
// Bench for io_input_bank: a default instance (S=2, D=0) and a debounced one (S=2, D=4).
module tb_io_input_bank;
    localparam int NP = 3;
    localparam int W  = 32;

    logic            io_clk = 1'b0;
    logic            reset;
    logic [NP*W-1:0] in_a;
    logic [NP*W-1:0] in_b;

    io_input_bank_if bus_a ();
    io_input_bank_if bus_b ();

    io_input_bank #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE(0)) dut_a (
        .io_clk(io_clk), .reset(reset), .in_port(in_a), .bus(bus_a)
    );
    io_input_bank #(.NPORTS(NP), .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE(4)) dut_b (
        .io_clk(io_clk), .reset(reset), .in_port(in_b), .bus(bus_b)
    );

    always #5 io_clk = ~io_clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] obs_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic expect_val(input string name, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic read_a(input logic [5:0] idx);
        bus_a.addr = {24'h0, idx, 2'b00};
        #1;
        obs_q.push_back(bus_a.io_read_data);
    endtask

    task automatic read_b(input logic [5:0] idx);
        bus_b.addr = {24'h0, idx, 2'b00};
        #1;
        obs_q.push_back(bus_b.io_read_data);
    endtask

    task automatic irq_a();
        obs_q.push_back({31'h0, bus_a.io_irq});
    endtask

    task automatic wr_a(input logic [5:0] idx, input logic [31:0] d);
        bus_a.addr     = {24'h0, idx, 2'b00};
        bus_a.io_wdata = d;
        bus_a.io_wr    = 1'b1;
        @(negedge io_clk);
        bus_a.io_wr    = 1'b0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [31:0] o;
        in_a = '1;
        in_b = '0;
        bus_a.addr = '0; bus_a.io_wr = 1'b0; bus_a.io_wdata = '0;
        bus_b.addr = '0; bus_b.io_wr = 1'b0; bus_b.io_wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge io_clk);
        reset = 1'b0;
        repeat (5) @(negedge io_clk);
        @(posedge io_clk);
        #3 reset = 1'b1;
        @(negedge io_clk);
        expect_val("rst_port0", 32'h0);  read_a(6'h00);
        expect_val("rst_port1", 32'h0);  read_a(6'h01);
        expect_val("rst_port2", 32'h0);  read_a(6'h02);
        expect_val("rst_status", 32'h0); read_a(6'h10);
        expect_val("rst_irq_en", 32'h0); read_a(6'h11);
        expect_val("rst_irq", 32'h0);    irq_a();
        expect_val("rst_b_port0", 32'h0); read_b(6'h00);
        @(negedge io_clk);
        reset = 1'b0;
        repeat (2) @(negedge io_clk);
        expect_val("rst_port0_edge2", 32'h0); read_a(6'h00);
        @(negedge io_clk);
        expect_val("rst_port0_edge3", 32'hFFFF_FFFF); read_a(6'h00);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
        repeat (2) @(negedge io_clk);
        wr_a(6'h10, 32'h7);
    endtask

    task automatic test_latency();
        exp_t        e;
        logic [31:0] o;
        expect_val("lat_status_clear", 32'h0); read_a(6'h10);
        @(negedge io_clk);
        in_a[1*W +: W] = 32'h1234_ABCD;
        repeat (2) @(negedge io_clk);
        expect_val("lat_port1_edge2", 32'hFFFF_FFFF); read_a(6'h01);
        expect_val("lat_status_edge2", 32'h0);        read_a(6'h10);
        @(negedge io_clk);
        expect_val("lat_port1_edge3", 32'h1234_ABCD); read_a(6'h01);
        expect_val("lat_status_edge3", 32'h2);        read_a(6'h10);
        expect_val("lat_port2_same", 32'hFFFF_FFFF);  read_a(6'h02);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
        wr_a(6'h10, 32'h2);
    endtask

    task automatic test_debounce();
        exp_t        e;
        logic [31:0] o;
        @(negedge io_clk);
        in_b[0 +: W] = 32'h0000_00A5;
        repeat (3) @(negedge io_clk);
        in_b[0 +: W] = 32'h0;
        repeat (10) @(negedge io_clk);
        expect_val("db_glitch_port0", 32'h0);  read_b(6'h00);
        expect_val("db_glitch_status", 32'h0); read_b(6'h10);
        @(negedge io_clk);
        in_b[0 +: W] = 32'h0000_00A5;
        repeat (6) @(negedge io_clk);
        expect_val("db_port0_edge6", 32'h0);  read_b(6'h00);
        expect_val("db_status_edge6", 32'h0); read_b(6'h10);
        @(negedge io_clk);
        expect_val("db_port0_edge7", 32'h0000_00A5); read_b(6'h00);
        expect_val("db_status_edge7", 32'h1);        read_b(6'h10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_irq_mask();
        exp_t        e;
        logic [31:0] o;
        wr_a(6'h11, 32'h4);
        expect_val("irq_en_read", 32'h4); read_a(6'h11);
        expect_val("irq_idle", 32'h0);    irq_a();
        in_a[2*W +: W] = 32'h0;
        repeat (2) @(negedge io_clk);
        expect_val("irq_edge2", 32'h0); irq_a();
        @(negedge io_clk);
        expect_val("irq_edge3", 32'h1);      irq_a();
        expect_val("irq_status", 32'h4);     read_a(6'h10);
        wr_a(6'h10, 32'h4);
        expect_val("irq_after_w1c", 32'h0);  irq_a();
        expect_val("irq_status_w1c", 32'h0); read_a(6'h10);
        in_a[0 +: W] = 32'h0000_0055;
        repeat (3) @(negedge io_clk);
        expect_val("mask_status", 32'h1); read_a(6'h10);
        expect_val("mask_irq", 32'h0);    irq_a();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
        wr_a(6'h10, 32'h1);
    endtask

    task automatic test_collision();
        exp_t        e;
        logic [31:0] o;
        expect_val("col_status_pre", 32'h0); read_a(6'h10);
        in_a[1*W +: W] = 32'hCAFE_F00D;
        repeat (2) @(negedge io_clk);
        wr_a(6'h10, 32'h2);
        expect_val("col_status", 32'h2);     read_a(6'h10);
        expect_val("col_port1", 32'hCAFE_F00D); read_a(6'h01);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_unmapped();
        exp_t        e;
        logic [31:0] o;
        expect_val("um_idx3f", 32'h0); read_a(6'h3F);
        expect_val("um_idx03", 32'h0); read_a(6'h03);
        expect_val("um_idx0f", 32'h0); read_a(6'h0F);
        expect_val("um_idx12", 32'h0); read_a(6'h12);
        wr_a(6'h05, 32'hFFFF_FFFF);
        wr_a(6'h3F, 32'hFFFF_FFFF);
        wr_a(6'h00, 32'h0);
        expect_val("um_port0", 32'h0000_0055);  read_a(6'h00);
        expect_val("um_port1", 32'hCAFE_F00D);  read_a(6'h01);
        expect_val("um_port2", 32'h0);          read_a(6'h02);
        expect_val("um_status", 32'h2);         read_a(6'h10);
        expect_val("um_irq_en", 32'h4);         read_a(6'h11);
        expect_val("um_irq", 32'h0);            irq_a();
        expect_val("um_idx05", 32'h0);          read_a(6'h05);
        bus_a.addr = 32'hABCD_0004;
        #1;
        expect_val("um_upper_addr", 32'hCAFE_F00D);
        obs_q.push_back(bus_a.io_read_data);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] o;
        @(negedge io_clk);
        wr_a(6'h11, 32'h1);
        wr_a(6'h11, 32'h6);
        expect_val("b2b_irq_pending", 32'h1); irq_a();
        wr_a(6'h10, 32'h2);
        expect_val("b2b_irq_en", 32'h6); read_a(6'h11);
        expect_val("b2b_status", 32'h0); read_a(6'h10);
        expect_val("b2b_irq", 32'h0);    irq_a();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_total++;
            if (o !== e.val) $display("FAIL %s: got %08h expected %08h", e.name, o, e.val);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_debounce();
        test_irq_mask();
        test_collision();
        test_unmapped();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "timeout");
    end
endmodule
